// File: rtl/version_frame_tx.sv
`default_nettype none

// +--------------------------------------------------------------------------+
// | version_pkg                                                              |
// | Build-identification constants used as default field values by          |
// | version_frame_tx. A build flow overwrites these per bitstream.           |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package version_pkg;
  localparam logic [7:0]  C_VERSION_MAJOR  = 8'd1;
  localparam logic [7:0]  C_VERSION_MINOR  = 8'd0;
  localparam logic [7:0]  C_VERSION_PATCH  = 8'd0;
  localparam logic [7:0]  C_VERSION_BUILD  = 8'd1;
  localparam logic [15:0] C_VERSION_YEAR   = 16'h2025;
  localparam logic [7:0]  C_VERSION_MONTH  = 8'h01;
  localparam logic [7:0]  C_VERSION_DAY    = 8'h01;
  localparam logic [7:0]  C_VERSION_HOUR   = 8'h00;
  localparam logic [7:0]  C_VERSION_MINUTE = 8'h00;
  localparam logic [7:0]  C_VERSION_SECOND = 8'h00;
endpackage

// +--------------------------------------------------------------------------+
// | version_frame_tx                                                         |
// | Emits the build-identification constants as a 13-byte framed,           |
// | XOR-checksummed stream on an AXI4-Stream-style byte port. A frame is     |
// | sent on request or on a periodic timer.                                  |
// | Frame: SYNC MAJ MIN PAT BLD YEARhi YEARlo MON DAY HR MIN SEC CHK         |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk          in   1   clock                                            |
// |   rst_n        in   1   synchronous active-low reset                     |
// |   req          in   1   single-cycle request for one frame               |
// |   m_tdata      out  8   frame byte                                       |
// |   m_tvalid     out  1   byte valid                                       |
// |   m_tready     in   1   downstream accept                                |
// |   m_tlast      out  1   high on the checksum byte                        |
// |   busy         out  1   frame in progress or pending                     |
// |   frame_count  out  16  completed frames (wraps)                         |
// +--------------------------------------------------------------------------+
module version_frame_tx #(
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
  parameter logic [31:0] PERIOD_CYCLES = 32'd0,
  parameter logic [7:0]  VER_MAJOR     = version_pkg::C_VERSION_MAJOR,
  parameter logic [7:0]  VER_MINOR     = version_pkg::C_VERSION_MINOR,
  parameter logic [7:0]  VER_PATCH     = version_pkg::C_VERSION_PATCH,
  parameter logic [7:0]  VER_BUILD     = version_pkg::C_VERSION_BUILD,
  parameter logic [15:0] VER_YEAR      = version_pkg::C_VERSION_YEAR,
  parameter logic [7:0]  VER_MONTH     = version_pkg::C_VERSION_MONTH,
  parameter logic [7:0]  VER_DAY       = version_pkg::C_VERSION_DAY,
  parameter logic [7:0]  VER_HOUR      = version_pkg::C_VERSION_HOUR,
  parameter logic [7:0]  VER_MINUTE    = version_pkg::C_VERSION_MINUTE,
  parameter logic [7:0]  VER_SECOND    = version_pkg::C_VERSION_SECOND
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        busy,
  output logic [15:0] frame_count
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SEND  = 1'b1;
  localparam logic [3:0] LAST_IDX = 4'd12;

  logic [0:0]  state_q,       state_d;
  logic [3:0]  index_q,       index_d;
  logic [7:0]  chk_q,         chk_d;
  logic        pending_q,     pending_d;
  logic [31:0] timer_q,       timer_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        tvalid_q,      tvalid_d;
  logic        tlast_q,       tlast_d;
  logic [7:0]  tdata_q,       tdata_d;

  logic        timer_expiry;
  logic        trigger;
  logic        xfer;
  logic [3:0]  next_index;
  logic [7:0]  chk_next;

  // Field bytes 0..11. The checksum byte is not in this table; it comes
  // from the running XOR accumulated while the fields are issued.
  function automatic logic [7:0] field_byte(input logic [3:0] idx);
    logic [7:0] b;
    case (idx)
      4'd0:    b = SYNC_BYTE;
      4'd1:    b = VER_MAJOR;
      4'd2:    b = VER_MINOR;
      4'd3:    b = VER_PATCH;
      4'd4:    b = VER_BUILD;
      4'd5:    b = VER_YEAR[15:8];
      4'd6:    b = VER_YEAR[7:0];
      4'd7:    b = VER_MONTH;
      4'd8:    b = VER_DAY;
      4'd9:    b = VER_HOUR;
      4'd10:   b = VER_MINUTE;
      4'd11:   b = VER_SECOND;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Free-running period timer. With PERIOD_CYCLES == 0 it is parked at zero
  // and never expires; the guard also keeps PERIOD_CYCLES-1 from wrapping.
  always_comb begin
    timer_expiry = (PERIOD_CYCLES != 32'd0) && (timer_q == PERIOD_CYCLES - 32'd1);
    if ((PERIOD_CYCLES == 32'd0) || timer_expiry) begin
      timer_d = 32'd0;
    end else begin
      timer_d = timer_q + 32'd1;
    end
  end

  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    chk_d         = chk_q;
    pending_d     = pending_q;
    frame_count_d = frame_count_q;
    tvalid_d      = tvalid_q;
    tlast_d       = tlast_q;
    tdata_d       = tdata_q;

    // req and timer expiry in the same cycle merge into one trigger.
    trigger    = req | timer_expiry;
    xfer       = tvalid_q & m_tready;
    next_index = index_q + 4'd1;
    // The byte currently on the bus is folded into the checksum as it is
    // accepted; the sync byte (index 0) is excluded.
    chk_next   = (index_q == 4'd0) ? chk_q : (chk_q ^ tdata_q);

    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          state_d  = ST_SEND;
          index_d  = 4'd0;
          chk_d    = 8'h00;
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
          tdata_d  = SYNC_BYTE;
        end
      end

      ST_SEND: begin
        // One-deep: any number of triggers during a frame collapse to one.
        if (trigger) begin
          pending_d = 1'b1;
        end
        if (xfer) begin
          if (index_q == LAST_IDX) begin
            frame_count_d = frame_count_q + 16'd1;
            index_d       = 4'd0;
            chk_d         = 8'h00;
            tlast_d       = 1'b0;
            // A trigger coinciding with the checksum transfer counts as
            // pending, so the next frame follows with no idle bubble.
            if (pending_q || trigger) begin
              pending_d = 1'b0;
              tdata_d   = SYNC_BYTE;
            end else begin
              state_d   = ST_IDLE;
              tvalid_d  = 1'b0;
              tdata_d   = 8'h00;
            end
          end else begin
            index_d = next_index;
            chk_d   = chk_next;
            if (next_index == LAST_IDX) begin
              tdata_d = chk_next;
              tlast_d = 1'b1;
            end else begin
              tdata_d = field_byte(next_index);
              tlast_d = 1'b0;
            end
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        index_d   = 4'd0;
        chk_d     = 8'h00;
        pending_d = 1'b0;
        tvalid_d  = 1'b0;
        tlast_d   = 1'b0;
        tdata_d   = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      index_q       <= 4'd0;
      chk_q         <= 8'h00;
      pending_q     <= 1'b0;
      timer_q       <= 32'd0;
      frame_count_q <= 16'd0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      tdata_q       <= 8'h00;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      chk_q         <= chk_d;
      pending_q     <= pending_d;
      timer_q       <= timer_d;
      frame_count_q <= frame_count_d;
      tvalid_q      <= tvalid_d;
      tlast_q       <= tlast_d;
      tdata_q       <= tdata_d;
    end
  end

  assign m_tdata     = tdata_q;
  assign m_tvalid    = tvalid_q;
  assign m_tlast     = tlast_q;
  assign busy        = (state_q == ST_SEND) | pending_q;
  assign frame_count = frame_count_q;

endmodule

`default_nettype wire

// File: tb/tb_version_frame_tx.sv
`default_nettype none

// +--------------------------------------------------------------------------+
// | tb_version_frame_tx                                                      |
// | Self-checking bench for version_frame_tx: one instance with the timer    |
// | disabled for request-driven scenarios, one with PERIOD_CYCLES=20.        |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_version_frame_tx;

  localparam logic [7:0]  T_MAJOR  = 8'd0;
  localparam logic [7:0]  T_MINOR  = 8'd0;
  localparam logic [7:0]  T_PATCH  = 8'd0;
  localparam logic [7:0]  T_BUILD  = 8'd67;
  localparam logic [15:0] T_YEAR   = 16'h2025;
  localparam logic [7:0]  T_MONTH  = 8'h11;
  localparam logic [7:0]  T_DAY    = 8'h10;
  localparam logic [7:0]  T_HOUR   = 8'h16;
  localparam logic [7:0]  T_MINUTE = 8'h14;
  localparam logic [7:0]  T_SECOND = 8'h34;
  localparam int          PERIOD   = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0_n, req0, rdy0, valid0, last0, busy0;
  logic [7:0]  data0;
  logic [15:0] cnt0;
  logic        rst1_n, req1, rdy1, valid1, last1, busy1;
  logic [7:0]  data1;
  logic [15:0] cnt1;

  version_frame_tx #(
    .SYNC_BYTE(8'hA5), .PERIOD_CYCLES(32'd0),
    .VER_MAJOR(T_MAJOR), .VER_MINOR(T_MINOR), .VER_PATCH(T_PATCH), .VER_BUILD(T_BUILD),
    .VER_YEAR(T_YEAR), .VER_MONTH(T_MONTH), .VER_DAY(T_DAY), .VER_HOUR(T_HOUR),
    .VER_MINUTE(T_MINUTE), .VER_SECOND(T_SECOND)
  ) u_dut0 (
    .clk(clk), .rst_n(rst0_n), .req(req0), .m_tdata(data0), .m_tvalid(valid0),
    .m_tready(rdy0), .m_tlast(last0), .busy(busy0), .frame_count(cnt0)
  );

  version_frame_tx #(
    .SYNC_BYTE(8'hA5), .PERIOD_CYCLES(32'(PERIOD)),
    .VER_MAJOR(T_MAJOR), .VER_MINOR(T_MINOR), .VER_PATCH(T_PATCH), .VER_BUILD(T_BUILD),
    .VER_YEAR(T_YEAR), .VER_MONTH(T_MONTH), .VER_DAY(T_DAY), .VER_HOUR(T_HOUR),
    .VER_MINUTE(T_MINUTE), .VER_SECOND(T_SECOND)
  ) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .req(req1), .m_tdata(data1), .m_tvalid(valid1),
    .m_tready(rdy1), .m_tlast(last1), .busy(busy1), .frame_count(cnt1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference frame built straight from the field list.
  logic [7:0] exp_frame [13];
  task automatic build_frame();
    logic [15:0] year_v;
    logic [7:0]  chk;
    year_v       = T_YEAR;
    exp_frame[0] = 8'hA5;
    exp_frame[1] = T_MAJOR;   exp_frame[2]  = T_MINOR;  exp_frame[3]  = T_PATCH;
    exp_frame[4] = T_BUILD;   exp_frame[5]  = year_v[15:8];
    exp_frame[6] = year_v[7:0];
    exp_frame[7] = T_MONTH;   exp_frame[8]  = T_DAY;    exp_frame[9]  = T_HOUR;
    exp_frame[10] = T_MINUTE; exp_frame[11] = T_SECOND;
    chk = 8'h00;
    for (int i = 1; i <= 11; i++) chk ^= exp_frame[i];
    exp_frame[12] = chk;
  endtask

  // Stream scoreboard for instance 0: byte order, stall stability,
  // no valid drop mid-frame, frame start/end cycle log.
  int sb_pos    = 0;
  int sb_frames = 0;
  int cyc       = 0;
  int starts[$];
  int ends[$];
  logic       pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [7:0] pd = 8'h00;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst0_n) begin
        sb_pos = 0;
        pv = 1'b0;
        pr = 1'b0;
      end else begin
        if (pv && !pr) begin
          check("stall_valid", 32'(valid0), 32'd1);
          check("stall_data", 32'(data0), 32'(pd));
          check("stall_last", 32'(last0), 32'(pl));
        end else if (sb_pos != 0) begin
          check("valid_mid_frame", 32'(valid0), 32'd1);
        end
        if (valid0 && rdy0) begin
          check("byte", 32'(data0), 32'(exp_frame[sb_pos]));
          check("tlast", 32'(last0), 32'(sb_pos == 12));
          if (sb_pos == 0) starts.push_back(cyc);
          if (sb_pos == 12) begin
            ends.push_back(cyc);
            sb_frames++;
            sb_pos = 0;
          end else begin
            sb_pos++;
          end
        end
        pv = valid0; pr = rdy0; pd = data0; pl = last0;
      end
    end
  end

  // Random backpressure driver, active only while rand_rdy is set.
  logic rand_rdy = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_rdy) rdy0 = 1'($urandom_range(0, 1));
    end
  end

  int exp_cnt = 0;   // expected DUT frame_count
  int exp_sb  = 0;   // expected completed frames seen on the stream

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while ((busy0 || valid0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= budget) check(tag, 32'(busy0 | valid0), 32'd0);
  endtask

  task automatic pulse_req();
    req0 = 1'b1;
    @(posedge clk); #1;
    req0 = 1'b0;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_frame_count"}, 32'(cnt0), 32'(exp_cnt));
    check({tag, "_frames_seen"}, 32'(sb_frames), 32'(exp_sb));
    check({tag, "_busy"}, 32'(busy0), 32'd0);
  endtask

  task automatic check_back_to_back(input string tag);
    if (starts.size() < 1 || ends.size() < 2) begin
      check({tag, "_frame_log"}, 32'(ends.size()), 32'd2);
    end else begin
      check({tag, "_gap"}, 32'(starts[starts.size()-1] - ends[ends.size()-2]), 32'd1);
    end
  endtask

  // Periodic instance: frames every PERIOD cycles, first one PERIOD cycles
  // after reset release (expiry at timer == PERIOD-1, valid one edge later).
  logic per_done = 1'b0;
  initial begin
    int k, first, last_start, n_start, n_end, pos;
    rst1_n = 1'b0; req1 = 1'b0; rdy1 = 1'b1;
    first = -1; last_start = 0; n_start = 0; n_end = 0; pos = 0;
    repeat (3) @(posedge clk);
    #1 rst1_n = 1'b1;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (first < 0 && k > 3 * PERIOD) break;
      if (first >= 0 && k >= first + 100) break;
      if (valid1 && rdy1) begin
        check("per_byte", 32'(data1), 32'(exp_frame[pos]));
        if (pos == 0) begin
          if (first < 0) begin
            first = k;
            check("per_first_start", 32'(k), 32'(PERIOD));
          end else begin
            check("per_spacing", 32'(k - last_start), 32'(PERIOD));
          end
          last_start = k;
          n_start++;
        end
        if (pos == 12) begin
          n_end++;
          pos = 0;
        end else begin
          pos++;
        end
      end
    end
    check("per_found_frame", 32'(first >= 0), 32'd1);
    check("per_starts", 32'(n_start), 32'd5);
    check("per_completed", 32'(n_end), 32'd5);
    check("per_frame_count", 32'(cnt1), 32'd5);
    per_done = 1'b1;
  end

  initial begin
    int a, b, c, n;
    build_frame();
    rst0_n = 1'b0; req0 = 1'b0; rdy0 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(valid0), 32'd0);
    check("rst_last", 32'(last0), 32'd0);
    check("rst_data", 32'(data0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_frame_count", 32'(cnt0), 32'd0);
    @(posedge clk); #1 rst0_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single frame, one-cycle request latency, 13 contiguous bytes.
    req0 = 1'b1;
    @(negedge clk);
    check("lat_before_edge", 32'(valid0), 32'd0);
    @(posedge clk); #1 req0 = 1'b0;
    @(negedge clk);
    check("lat_valid", 32'(valid0), 32'd1);
    check("lat_data", 32'(data0), 32'hA5);
    exp_cnt++; exp_sb++;
    wait_idle(100, "single_timeout");
    check_counts("single");
    if (starts.size() > 0 && ends.size() > 0)
      check("single_length", 32'(ends[ends.size()-1] - starts[starts.size()-1]), 32'd12);

    // Random backpressure, several frames.
    for (int it = 0; it < 3; it++) begin
      rand_rdy = 1'b1;
      repeat (int'($urandom_range(0, 3))) @(posedge clk);
      #1;
      pulse_req();
      exp_cnt++; exp_sb++;
      wait_idle(400, "bp_timeout");
      rand_rdy = 1'b0; rdy0 = 1'b1;
      check_counts("backpressure");
      @(posedge clk); #1;
    end

    // Three requests during bytes 2..8 collapse into one extra frame.
    pulse_req();
    a = 2 + int'($urandom_range(0, 1));
    b = a + 2;
    c = b + 2 + int'($urandom_range(0, 1));
    for (int t = 1; t <= c; t++) begin
      @(posedge clk); #1;
      req0 = (t == a || t == b || t == c);
    end
    @(posedge clk); #1 req0 = 1'b0;
    exp_cnt += 2; exp_sb += 2;
    wait_idle(100, "pending_timeout");
    check_counts("pending");
    check_back_to_back("pending");

    // Request coinciding with the checksum transfer.
    @(posedge clk); #1;
    pulse_req();
    n = 0;
    while (!last0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("coinc_saw_last", 32'(last0), 32'd1);
    pulse_req();
    exp_cnt += 2; exp_sb += 2;
    wait_idle(100, "coinc_timeout");
    check_counts("coincidence");
    check_back_to_back("coincidence");

    // Reset while byte 6 is on the bus.
    @(posedge clk); #1;
    pulse_req();
    n = 0;
    while (sb_pos != 6 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("abort_reached_byte6", 32'(sb_pos), 32'd6);
    rst0_n = 1'b0;
    @(posedge clk); #1 rst0_n = 1'b1;
    @(negedge clk);
    check("abort_valid", 32'(valid0), 32'd0);
    check("abort_last", 32'(last0), 32'd0);
    check("abort_frame_count", 32'(cnt0), 32'd0);
    check("abort_busy", 32'(busy0), 32'd0);
    exp_cnt = 0;
    @(posedge clk); #1;
    req0 = 1'b1;
    @(posedge clk); #1 req0 = 1'b0;
    @(negedge clk);
    check("abort_restart_data", 32'(data0), 32'hA5);
    exp_cnt++; exp_sb++;
    wait_idle(100, "abort_timeout");
    check_counts("after_abort");

    n = 0;
    while (!per_done && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check("periodic_done", 32'(per_done), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/version_frame_tx.md
Name: version_frame_tx

Overview:
- Sequencer that reads the build-identification constants (version and build timestamp) and emits them as a framed, checksummed byte stream on an AXI4-Stream-style byte port.
- A frame is sent on an explicit request or on a periodic timer.
- Sits between the version constants and the host-facing byte link (UART/debug transport), so software can read which bitstream is loaded without a register map.

Parameters:
- SYNC_BYTE, 8'hA5, first byte of every frame.
- PERIOD_CYCLES, 0, clock cycles between automatic frames; 0 disables periodic sending. 32-bit.
- VER_MAJOR / VER_MINOR / VER_PATCH / VER_BUILD, version_pkg C_VERSION_* values, 8-bit version fields.
- VER_YEAR, version_pkg C_VERSION_YEAR, 16-bit BCD year.
- VER_MONTH / VER_DAY / VER_HOUR / VER_MINUTE / VER_SECOND, version_pkg C_VERSION_* values, 8-bit BCD fields.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  synchronous, active-low reset.
- req  in  1  single-cycle request for one frame.
- m_tdata  out  8  frame byte.
- m_tvalid  out  1  byte valid.
- m_tready  in  1  downstream accept.
- m_tlast  out  1  high on the final (checksum) byte.
- busy  out  1  high while a frame is in progress or pending.
- frame_count  out  16  count of completed frames; wraps at 0xFFFF->0.

Behaviour:
- Clock and reset: one clock; synchronous, active-low reset rst_n.
- Reset values: m_tvalid=0, m_tlast=0, m_tdata=0, busy=0, frame_count=0, pending=0, timer=0, state=IDLE.
- Reset mid-frame aborts the frame immediately. There is no resume; the next frame starts from byte 0.
- Frame is 13 bytes, in this index order:
  - 0: SYNC_BYTE
  - 1: MAJOR
  - 2: MINOR
  - 3: PATCH
  - 4: BUILD
  - 5: YEAR[15:8]
  - 6: YEAR[7:0]
  - 7: MONTH
  - 8: DAY
  - 9: HOUR
  - 10: MINUTE
  - 11: SECOND
  - 12: CHK
- CHK is the XOR of bytes 1..11 (SYNC excluded), accumulated as bytes are issued; not precomputed combinationally over all fields.
- States:
  - IDLE: no output. A trigger (req, or timer expiry) moves to SEND on the next edge, with index=0 and m_tvalid=1 on that edge. Latency from req to first valid: 1 cycle.
  - SEND: m_tdata = byte[index]. A transfer occurs when m_tvalid && m_tready; on a transfer, index increments.
    - At index 12, m_tlast=1.
    - A transfer at index 12 increments frame_count, and the state goes to IDLE, or restarts at index 0 if pending=1 (pending cleared, m_tvalid stays 1, no bubble).
- Handshake rules:
  - While m_tvalid=1 and m_tready=0, m_tdata and m_tlast hold stable.
  - m_tvalid never drops mid-frame.
  - Full throughput is one byte per cycle when m_tready is held high: 13 cycles per frame.
- Triggers during SEND set pending; this is one-deep, so multiple triggers collapse into one extra frame.
- A trigger in the same cycle as the last-byte transfer also sets pending, so a back-to-back frame follows.
- busy = (state==SEND) || pending.
- Timer (PERIOD_CYCLES>0):
  - Free-running count from 0 to PERIOD_CYCLES-1, then wraps to 0.
  - Expiry is the cycle where timer == PERIOD_CYCLES-1, and counts as a trigger.
  - Expiry is independent of state; during SEND it sets pending.
  - req and expiry in the same cycle produce one trigger.
- PERIOD_CYCLES=0: the timer is held at 0 and never fires.
- frame_count increments only on completed frames; aborted (reset) frames do not count.

Test Plan:
- Test field overrides for all scenarios: MAJOR=0, MINOR=0, PATCH=0, BUILD=8'd67, YEAR=16'h2025, MONTH=8'h11, DAY=8'h10, HOUR=8'h16, MINUTE=8'h14, SECOND=8'h34.
- Single frame: m_tready=1, one req pulse -> m_tvalid rises 1 cycle later; 13 consecutive bytes A5 00 00 00 43 20 25 11 10 16 14 34 71; m_tlast only on 0x71; frame_count=1; busy low after.
- Backpressure: random m_tready (about 50%) -> identical byte sequence; m_tdata and m_tlast stable on every stalled cycle; m_tvalid never drops mid-frame.
- Pending collapse: three req pulses during bytes 2-8 -> exactly two frames back-to-back, with no idle cycle between the 0x71 and the next A5; frame_count=2.
- Last-byte coincidence: req in the same cycle as the 0x71 transfer -> second frame starts on the next cycle; frame_count=2.
- Periodic: PERIOD_CYCLES=20, m_tready=1, no req, run 100 cycles -> frames start at a fixed 20-cycle spacing; 5 frames complete (A5 bytes 20 cycles apart).
- Reset mid-frame: rst_n low at byte 6 for 1 cycle -> next cycle m_tvalid=0 and frame_count=0; a subsequent req yields a full frame starting with A5; frame_count=1.
